// File: rtl/sos_control.sv
// Sequencer that walks the S/O pulse generator through "S O S", once, N times or until abort.
// Owns the generator's func_start/func_done handshake and times inter-letter/inter-word gaps.
module sos_control #(
  parameter logic [15:0] T1MS          = 16'd49_999,
  parameter logic [9:0]  LETTER_GAP_MS = 10'd100,
  parameter logic [9:0]  WORD_GAP_MS   = 10'd300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] repeat_num,
  input  logic       func_done,
  output logic [1:0] func_start,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [1:0] letter_idx,
  output logic [3:0] word_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DONE = 3'd2,
    LGAP      = 3'd3,
    WGAP      = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t      state_r;
  logic [3:0]  rep_r;
  logic        abort_pend_r;
  logic [15:0] pre_r;
  logic [9:0]  ms_r;

  logic        abort_s;
  logic [3:0]  word_next_s;
  logic [9:0]  gap_len_s;
  logic        ms_tick_s;
  logic        gap_end_s;

  // Letter positions 0 and 2 are S, position 1 is O.
  function automatic logic [1:0] letter_code(input logic [1:0] idx);
    case (idx)
      2'd1:    letter_code = 2'b01;
      default: letter_code = 2'b10;
    endcase
  endfunction

  // Abort qualification, next word count and gap terminal-count decode.
  always_comb begin
    abort_s     = abort_pend_r | abort;
    word_next_s = word_cnt + 4'd1;
    gap_len_s   = (state_r == WGAP) ? WORD_GAP_MS : LETTER_GAP_MS;
    ms_tick_s   = (pre_r == T1MS);
    gap_end_s   = (gap_len_s == 10'd0) || (ms_tick_s && (ms_r == (gap_len_s - 10'd1)));
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rep_r        <= 4'd0;
      abort_pend_r <= 1'b0;
      pre_r        <= 16'd0;
      ms_r         <= 10'd0;
      func_start   <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      letter_idx   <= 2'd0;
      word_cnt     <= 4'd0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            rep_r        <= repeat_num;
            letter_idx   <= 2'd0;
            word_cnt     <= 4'd0;
            abort_pend_r <= 1'b0;
            busy         <= 1'b1;
            func_start   <= letter_code(2'd0);
            state_r      <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          abort_pend_r <= abort_s;
          state_r      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          abort_pend_r <= abort_s;
          // The request is held through the done cycle and dropped on this edge.
          if (func_done) begin
            func_start <= 2'b00;
            if (abort_s) begin
              done    <= 1'b1;
              aborted <= 1'b1;
              state_r <= FINISH;
            end else if (letter_idx < 2'd2) begin
              letter_idx <= letter_idx + 2'd1;
              pre_r      <= 16'd0;
              ms_r       <= 10'd0;
              state_r    <= LGAP;
            end else begin
              word_cnt   <= word_next_s;
              letter_idx <= 2'd0;
              if ((rep_r != 4'd0) && (word_next_s == rep_r)) begin
                done    <= 1'b1;
                state_r <= FINISH;
              end else begin
                pre_r   <= 16'd0;
                ms_r    <= 10'd0;
                state_r <= WGAP;
              end
            end
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        LGAP, WGAP: begin
          abort_pend_r <= abort_s;
          if (abort_s) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            state_r <= FINISH;
          end else if (gap_end_s) begin
            func_start <= letter_code(letter_idx);
            state_r    <= REQ;
          end else if (ms_tick_s) begin
            pre_r <= 16'd0;
            ms_r  <= ms_r + 10'd1;
          end else begin
            pre_r <= pre_r + 16'd1;
          end
        end
        FINISH: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          func_start <= 2'b00;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sos_control.sv
// Directed bench for sos_control: scoreboard of expected letters and gap lengths,
// plus a behavioural pulse-generator model per instance (timed gaps and zero gaps).
module tb_sos_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] repeat_num = 4'd0;
  logic       sel = 1'b0;

  logic [1:0] fs_a, fs_z, li_a, li_z;
  logic       busy_a, busy_z, done_a, done_z, ab_a, ab_z;
  logic [3:0] wc_a, wc_z;
  logic [1:0] g_fd;

  always #5 clk = ~clk;

  sos_control #(.T1MS(16'd9), .LETTER_GAP_MS(10'd2), .WORD_GAP_MS(10'd3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .repeat_num(repeat_num),
    .func_done(g_fd[0]), .func_start(fs_a), .busy(busy_a), .done(done_a),
    .aborted(ab_a), .letter_idx(li_a), .word_cnt(wc_a));

  sos_control #(.T1MS(16'd9), .LETTER_GAP_MS(10'd0), .WORD_GAP_MS(10'd0)) dut_z (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .repeat_num(repeat_num),
    .func_done(g_fd[1]), .func_start(fs_z), .busy(busy_z), .done(done_z),
    .aborted(ab_z), .letter_idx(li_z), .word_cnt(wc_z));

  // Pulse-generator model: done 5 cycles after start rises, start must be held through done
  logic [1:0] g_fs [2];
  logic       g_act [2];
  logic [2:0] g_cnt [2];
  logic       g_post [2];
  int         g_err [2];
  assign g_fs[0] = fs_a;
  assign g_fs[1] = fs_z;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        g_act[k] <= 1'b0; g_cnt[k] <= 3'd0; g_fd[k] <= 1'b0; g_post[k] <= 1'b0;
      end else begin
        g_post[k] <= 1'b0;
        if (g_post[k] && g_fs[k] != 2'b00) g_err[k] <= g_err[k] + 1;
        if (g_fd[k]) begin
          if (g_fs[k] == 2'b00) g_err[k] <= g_err[k] + 1;
          g_fd[k] <= 1'b0; g_act[k] <= 1'b0; g_post[k] <= 1'b1;
        end else if (g_act[k]) begin
          if (g_fs[k] == 2'b00) g_err[k] <= g_err[k] + 1;
          g_cnt[k] <= g_cnt[k] + 3'd1;
          if (g_cnt[k] == 3'd3) g_fd[k] <= 1'b1;
        end else if (g_fs[k] != 2'b00) begin
          g_act[k] <= 1'b1; g_cnt[k] <= 3'd0;
        end
      end
    end
  end

  logic [1:0] m_fs, m_li;
  logic       m_busy, m_done, m_ab;
  logic [3:0] m_wc;
  assign m_fs   = sel ? fs_z   : fs_a;
  assign m_busy = sel ? busy_z : busy_a;
  assign m_done = sel ? done_z : done_a;
  assign m_ab   = sel ? ab_z   : ab_a;
  assign m_li   = sel ? li_z   : li_a;
  assign m_wc   = sel ? wc_z   : wc_a;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_let [$];
  int         exp_gap [$];
  logic [1:0] prev_fs = 2'b00;
  logic       gap_active = 1'b0;
  int         zero_run = 0;
  int         done_cnt = 0;
  int         ab_cnt = 0;
  logic [3:0] done_wc = 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; sample at negedge and score requests, gaps and done pulses
  task automatic step();
    @(negedge clk);
    if (rst) begin
      prev_fs = 2'b00; gap_active = 1'b0; zero_run = 0;
    end else begin
      if (m_fs == 2'b11) check("fs_is_11", m_fs, 2'b00);
      if (prev_fs == 2'b00 && m_fs != 2'b00) begin
        if (exp_let.size() == 0) check("unexpected_req", m_fs, 2'b00);
        else check("letter", m_fs, exp_let.pop_front());
        if (gap_active) begin
          if (exp_gap.size() == 0) check("unexpected_gap", zero_run, 0);
          else check("gap_len", zero_run, exp_gap.pop_front());
        end
        gap_active = 1'b0;
      end else if (prev_fs != 2'b00 && m_fs == 2'b00) begin
        gap_active = 1'b1; zero_run = 1;
      end else if (gap_active && m_fs == 2'b00) begin
        zero_run++;
      end
      if (m_ab && !m_done) check("aborted_without_done", m_ab, 1'b0);
      if (m_done) begin
        done_cnt++; done_wc = m_wc; gap_active = 1'b0;
        if (m_ab) ab_cnt++;
      end
      prev_fs = m_fs;
    end
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget && done_cnt == base; i++) step();
    check("done_seen", done_cnt - base, 1);
  endtask

  task automatic wait_fs(input logic [1:0] code, input int budget);
    for (int i = 0; i < budget && m_fs != code; i++) step();
    check("wait_fs", m_fs, code);
  endtask

  task automatic wait_wc(input logic [3:0] wc, input int budget);
    for (int i = 0; i < budget && m_wc != wc; i++) step();
    check("wait_wc", m_wc, wc);
  endtask

  task automatic clear();
    exp_let.delete(); exp_gap.delete(); done_cnt = 0; ab_cnt = 0;
  endtask

  task automatic push_word(input int lgap, input logic with_wgap, input int wgap);
    exp_let.push_back(2'b10); exp_let.push_back(2'b01); exp_let.push_back(2'b10);
    exp_gap.push_back(lgap); exp_gap.push_back(lgap);
    if (with_wgap) exp_gap.push_back(wgap);
  endtask

  task automatic pulse_start(input logic with_abort);
    start = 1'b1; abort = with_abort; step(); start = 1'b0; abort = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0; clear(); step();
  endtask

  initial begin
    // reset state
    repeat (3) step();
    check("rst_fs", m_fs, 2'b00);
    check("rst_busy", m_busy, 1'b0);
    check("rst_done", m_done, 1'b0);
    check("rst_aborted", m_ab, 1'b0);
    check("rst_letter_idx", m_li, 2'd0);
    check("rst_word_cnt", m_wc, 4'd0);
    rst = 1'b0; step();

    // single word
    clear(); repeat_num = 4'd1; push_word(20, 1'b0, 0);
    pulse_start(1'b0);
    check("t1_busy_start", m_busy, 1'b1);
    check("t1_fs_first", m_fs, 2'b10);
    wait_done(400);
    check("t1_word_cnt", done_wc, 4'd1);
    check("t1_aborted", ab_cnt, 0);
    step(); check("t1_busy_off", m_busy, 1'b0);
    repeat (30) step();
    check("t1_done_once", done_cnt, 1);
    check("t1_queue_empty", exp_let.size() + exp_gap.size(), 0);

    // three words with word gaps
    clear(); repeat_num = 4'd3;
    push_word(20, 1'b1, 30); push_word(20, 1'b1, 30); push_word(20, 1'b0, 0);
    pulse_start(1'b0);
    wait_done(1500);
    check("t2_word_cnt", done_wc, 4'd3);
    check("t2_aborted", ab_cnt, 0);
    repeat (30) step();
    check("t2_queue_empty", exp_let.size() + exp_gap.size(), 0);

    // continuous, abort during the O request
    clear(); repeat_num = 4'd0;
    exp_let.push_back(2'b10); exp_let.push_back(2'b01); exp_gap.push_back(20);
    pulse_start(1'b0);
    wait_fs(2'b01, 200);
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    wait_done(100);
    check("t3_aborted", ab_cnt, 1);
    check("t3_word_cnt", done_wc, 4'd0);
    repeat (40) step();
    check("t3_done_once", done_cnt, 1);
    check("t3_queue_empty", exp_let.size() + exp_gap.size(), 0);

    // abort during a word gap
    clear(); repeat_num = 4'd0; push_word(20, 1'b0, 0);
    pulse_start(1'b0);
    wait_wc(4'd1, 400);
    repeat (5) step();
    abort = 1'b1; step(); abort = 1'b0;
    check("t4_done_next_edge", done_cnt, 1);
    check("t4_aborted", ab_cnt, 1);
    step(); check("t4_busy_off", m_busy, 1'b0);
    repeat (40) step();
    check("t4_queue_empty", exp_let.size() + exp_gap.size(), 0);

    // start+abort in IDLE starts normally; start while busy is ignored
    clear(); repeat_num = 4'd1; push_word(20, 1'b0, 0);
    pulse_start(1'b1);
    check("t5_busy_start", m_busy, 1'b1);
    repeat (10) step();
    pulse_start(1'b0);
    wait_done(400);
    check("t5_aborted", ab_cnt, 0);
    check("t5_word_cnt", done_wc, 4'd1);
    repeat (40) step();
    check("t5_done_once", done_cnt, 1);
    check("t5_queue_empty", exp_let.size() + exp_gap.size(), 0);

    // zero-length gaps on the second instance
    rst = 1'b1; sel = 1'b1; step(); step(); rst = 1'b0; clear(); step();
    repeat_num = 4'd2; push_word(1, 1'b1, 1); push_word(1, 1'b0, 0);
    pulse_start(1'b0);
    wait_done(300);
    check("t6_word_cnt", done_wc, 4'd2);
    check("t6_aborted", ab_cnt, 0);
    repeat (20) step();
    check("t6_queue_empty", exp_let.size() + exp_gap.size(), 0);

    // reset in WAIT_DONE, then a fresh word
    rst = 1'b1; sel = 1'b0; step(); step(); rst = 1'b0; clear(); step();
    repeat_num = 4'd1; exp_let.push_back(2'b10);
    pulse_start(1'b0);
    step(); step();
    check("t7_in_wait", m_fs, 2'b10);
    rst = 1'b1; step();
    check("t7_rst_fs", m_fs, 2'b00);
    check("t7_rst_busy", m_busy, 1'b0);
    check("t7_rst_done", m_done, 1'b0);
    rst = 1'b0; clear(); step();
    push_word(20, 1'b0, 0);
    pulse_start(1'b0);
    wait_done(400);
    check("t7_word_cnt", done_wc, 4'd1);
    check("t7_aborted", ab_cnt, 0);
    repeat (20) step();
    check("t7_queue_empty", exp_let.size() + exp_gap.size(), 0);

    check("gen_protocol_a", g_err[0], 0);
    check("gen_protocol_z", g_err[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sos_control.md
Name: sos_control

Overview:
- Sequencer that drives the S/O Morse pulse generator through the word "S O S", once per call or repeated.
- Per letter: issues a one-hot letter request, waits for the generator's done handshake, then inserts a programmable inter-letter gap. Inserts a longer inter-word gap between repeats.
- Sits between the user/key interface and the pulse generator. It is the only master of that generator's func_start/func_done pair.

Parameters:
- T1MS, 16'd49_999: ms prescaler terminal count (50 MHz clock); one ms = T1MS+1 cycles.
- LETTER_GAP_MS, 10'd100: extra silence after each letter, in ms; 0 means no gap.
- WORD_GAP_MS, 10'd300: silence between repeated words, in ms; 0 means no gap.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: request to send; sampled only in IDLE.
- abort, input, 1: request to stop early; sampled only while busy.
- repeat_num, input, 4: number of words to send; 0 means continuous until abort. Latched on accepted start.
- func_done, input, 1: done pulse from the pulse generator.
- func_start, output, 2: letter request; 2'b10 = S, 2'b01 = O, 2'b00 = none. Never 2'b11.
- busy, output, 1: high from accepted start until the done pulse, inclusive.
- done, output, 1: one-cycle pulse when the sequence ends, normally or by abort.
- aborted, output, 1: one-cycle pulse coincident with done when the end was caused by abort.
- letter_idx, output, 2: current letter position, 0..2.
- word_cnt, output, 4: number of words completed, wraps mod 16.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; all outputs 0; prescaler, gap counter, latches and abort_pend cleared. Applies mid-operation too. The system must reset the pulse generator on the same reset.
- States: IDLE, REQ, WAIT_DONE, LGAP, WGAP, FINISH.
- IDLE:
  - start=1 at edge N: latch repeat_num, clear letter_idx, word_cnt and abort_pend, go to REQ.
  - At N+1: busy=1 and func_start=2'b10.
  - abort is ignored in IDLE. start together with abort in IDLE means the start is accepted.
- REQ: drive func_start per letter_idx (0 = S, 1 = O, 2 = S), go to WAIT_DONE. func_start is registered and stays constant through WAIT_DONE.
- WAIT_DONE:
  - Hold func_start until func_done=1 is sampled. The generator needs start high during its done cycle, so func_start clears on the edge after that sample, not before.
  - On that edge, if abort_pend, go to FINISH with aborted.
  - Else if letter_idx<2: letter_idx+1, go to LGAP.
  - Else: word_cnt+1, letter_idx=0. Then if repeat_num≠0 and the new word_cnt==repeat_num, go to FINISH; otherwise go to WGAP.
  - abort never cuts a letter short.
- Gap handling:
  - LGAP and WGAP last exactly N×(T1MS+1) cycles (N = LETTER_GAP_MS or WORD_GAP_MS), then go to REQ.
  - The prescaler and ms counter are cleared on gap entry.
  - If N=0, the gap state lasts 1 cycle.
  - func_start=0 throughout a gap.
- Abort:
  - abort=1 in any busy state sets abort_pend.
  - In LGAP or WGAP, a pending abort ends the gap on the next edge and goes to FINISH.
  - abort during FINISH is ignored.
- FINISH: one cycle. done=1, aborted=abort_pend, busy=1. Next state IDLE with busy=0.
- Word-count wrap: word_cnt wraps 15→0. The comparison against repeat_num uses the wrapped value, so repeat_num≤15 is exact.
- start while busy is ignored and not queued.

Test Plan:
Test parameters: T1MS=9, LETTER_GAP_MS=2, WORD_GAP_MS=3. Generator model returns a 1-cycle func_done 5 cycles after func_start rises and requires start held through the done cycle.
- Single word, repeat_num=1:
  - func_start sequence is 10, 01, 10.
  - Each request drops on the cycle after func_done.
  - Each LGAP is 20 cycles; no WGAP.
  - done=1 and aborted=0 exactly once; word_cnt=1; then busy=0.
- Repeat, repeat_num=3: 9 letter requests; 2 WGAPs of 30 cycles each; done after the 3rd word; word_cnt=3.
- Continuous, repeat_num=0, abort pulsed mid-O request:
  - O completes and func_done is honoured.
  - No further request is issued.
  - done and aborted pulse together.
  - Generator model is never left with start high after its done.
- Abort during WGAP (repeat_num=0): gap ends next edge, FINISH pulse, IDLE; no new S issued.
- Start during busy is ignored. start and abort together in IDLE start normally. Gap parameters = 0 give 1-cycle gaps.
- rst=1 mid WAIT_DONE: next edge, func_start=0, busy=0, state IDLE. A fresh start then sends a full word correctly.
